// File: rtl/cache_pkg.sv
// Shared constants and types for the cache line-fill path.
// Geometry: WORDS_PER_LINE words of WORD_W bits form one LINE_W-bit line,
// addressed with ADDR_W-bit byte addresses.
package cache_pkg;

    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned LINE_W         = WORDS_PER_LINE * WORD_W;
    localparam int unsigned BYTE_OFFSET_W  = $clog2(LINE_W / 8);
    localparam int unsigned BEAT_W         = $clog2(WORDS_PER_LINE);
    localparam int unsigned WORD_BYTES_W   = $clog2(WORD_W / 8);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } fill_state_t;

endpackage

// File: rtl/line_fill_buf.sv
// Line assembly register: one LINE_W-bit register written a word at a time.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (clears the line)
//   wr_en     - write wr_data into word slot wr_idx this cycle
//   wr_idx    - word slot index
//   wr_data   - word to store
//   line      - current line contents, word k at [k*WORD_W +: WORD_W]
module line_fill_buf
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    output logic [LINE_W-1:0] line
);

    logic [LINE_W-1:0] line_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (wr_en) begin
            line_q[wr_idx*WORD_W +: WORD_W] <= wr_data;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/line_fill_ctrl.sv
// Cache line-fill sequencer. On fill_req it fetches every word of the line
// containing fill_addr, lowest address first, one single-beat read at a time
// over a req/gnt + rvalid handshake, and pulses fill_done when the line is
// assembled. Errors are accumulated and reported with fill_done; they never
// cut a fill short, so memory is never left with an orphan request.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   fill_req, fill_addr  - fill request and any byte address in the line
//   fill_busy            - high whenever not idle
//   fill_done, fill_err  - one-cycle completion pulse and error status
//   fill_line            - assembled line
//   mem_req, mem_addr    - read request and word-aligned beat address
//   mem_gnt              - request accepted
//   mem_rvalid, mem_rdata, mem_err - read response
module line_fill_ctrl
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_req,
    input  logic [ADDR_W-1:0] fill_addr,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              fill_err,
    output logic [LINE_W-1:0] fill_line,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_err
);

    localparam int unsigned LineAddrW = ADDR_W - BYTE_OFFSET_W;

    fill_state_t          state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    // Only the line-number bits are kept; the offset bits are always zero.
    logic [LineAddrW-1:0] base_q, base_d;
    logic                 err_q, err_d;
    logic                 wr_en;

    logic unused_fill_addr;
    assign unused_fill_addr = ^fill_addr[BYTE_OFFSET_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        err_d   = err_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    base_d  = fill_addr[ADDR_W-1:BYTE_OFFSET_W];
                    beat_d  = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // rvalid here (including the grant cycle) belongs to no beat.
                if (mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    wr_en = 1'b1;
                    err_d = err_q | mem_err;
                    if (beat_q == BEAT_W'(WORDS_PER_LINE - 1)) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode registered state only.
    assign fill_busy = (state_q != IDLE);
    assign fill_done = (state_q == DONE);
    assign fill_err  = (state_q == DONE) & err_q;
    assign mem_req   = (state_q == REQ);
    // Base offset bits are zero, so concatenation is the same as base + beat*bytes.
    assign mem_addr  = {base_q, beat_q, {WORD_BYTES_W{1'b0}}};

    line_fill_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_idx  (beat_q),
        .wr_data (mem_rdata),
        .line    (fill_line)
    );

endmodule

// File: tb/tb_line_fill_ctrl.sv
module tb_line_fill_ctrl;
    import cache_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_busy;
    logic              fill_done;
    logic              fill_err;
    logic [LINE_W-1:0] fill_line;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_err;

    int n_vec = 0;
    int n_err = 0;
    int gnt_wait [WORDS_PER_LINE];
    int rv_wait  [WORDS_PER_LINE];

    always #5 clk = ~clk;

    line_fill_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .fill_err   (fill_err),
        .fill_line  (fill_line),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                            input logic [LINE_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_waits();
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            gnt_wait[k] = 0;
            rv_wait[k]  = 0;
        end
    endtask

    // Drives one fill and plays the memory side. Slot k returns data_base+k.
    // abort_beat >= 0: reset is asserted in WAIT of that beat and the task returns.
    task automatic run_fill(input logic [ADDR_W-1:0] addr, input logic [WORD_W-1:0] data_base,
                            input int err_beat, input bit hold_req, input bit spurious,
                            input int abort_beat, input int exp_lat);
        logic [ADDR_W-1:0] base;
        int cyc;
        base      = addr & ~32'h1F;
        fill_req  = 1'b1;
        fill_addr = addr;
        step();
        cyc = 1;
        if (!hold_req) fill_req = 1'b0;
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            for (int w = 0; w <= gnt_wait[k]; w++) begin
                check_eq($sformatf("req_b%0d", k), LINE_W'(mem_req), 1);
                check_eq($sformatf("addr_b%0d", k), LINE_W'(mem_addr), LINE_W'(base + 32'(4 * k)));
                check_eq("busy", LINE_W'(fill_busy), 1);
                check_eq("done_early", LINE_W'(fill_done), 0);
                mem_gnt = (w == gnt_wait[k]);
                if (spurious) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hDEAD_BEEF;
                end
                step();
                cyc++;
            end
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (k == abort_beat) begin
                rst = 1'b1;
                #1;
                check_eq("abort_req", LINE_W'(mem_req), 0);
                check_eq("abort_busy", LINE_W'(fill_busy), 0);
                check_eq("abort_line", fill_line, 0);
                check_eq("abort_done", LINE_W'(fill_done), 0);
                step();
                rst = 1'b0;
                step();
                check_eq("abort_done2", LINE_W'(fill_done), 0);
                check_eq("abort_idle", LINE_W'(fill_busy), 0);
                return;
            end
            for (int w = 0; w <= rv_wait[k]; w++) begin
                check_eq($sformatf("wait_req_b%0d", k), LINE_W'(mem_req), 0);
                check_eq("done_early", LINE_W'(fill_done), 0);
                mem_rvalid = (w == rv_wait[k]);
                mem_rdata  = data_base + WORD_W'(k);
                mem_err    = (k == err_beat) && (w == rv_wait[k]);
                step();
                cyc++;
            end
            mem_rvalid = 1'b0;
            mem_err    = 1'b0;
        end
        check_eq("done", LINE_W'(fill_done), 1);
        check_eq("err", LINE_W'(fill_err), LINE_W'(err_beat >= 0));
        check_eq("latency", LINE_W'(cyc), LINE_W'(exp_lat));
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            check_eq($sformatf("slot%0d", k), LINE_W'(fill_line[k*WORD_W +: WORD_W]),
                     LINE_W'(data_base + WORD_W'(k)));
        end
        step();
        check_eq("done_pulse", LINE_W'(fill_done), 0);
        check_eq("idle_after", LINE_W'(fill_busy), 0);
    endtask

    initial begin
        rst        = 1'b1;
        fill_req   = 1'b0;
        fill_addr  = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        mem_err    = 1'b0;
        clear_waits();
        step();
        step();
        check_eq("rst_req", LINE_W'(mem_req), 0);
        check_eq("rst_addr", LINE_W'(mem_addr), 0);
        check_eq("rst_busy", LINE_W'(fill_busy), 0);
        check_eq("rst_done", LINE_W'(fill_done), 0);
        check_eq("rst_err", LINE_W'(fill_err), 0);
        check_eq("rst_line", fill_line, 0);
        rst = 1'b0;
        step();

        // Zero-wait fill.
        run_fill(32'h0000_1234, 32'hA0, -1, 1'b0, 1'b0, -1, 17);
        check_eq("word0_a0", LINE_W'(fill_line[31:0]), LINE_W'(32'hA0));

        // Back-pressure: grant 3 late on beat 2, rvalid 4 late on beat 5.
        gnt_wait[2] = 3;
        rv_wait[5]  = 4;
        run_fill(32'h0000_1234, 32'h100, -1, 1'b0, 1'b0, -1, 24);
        clear_waits();

        // Error on beat 3 does not stop the fill.
        run_fill(32'h0000_2010, 32'h300, 3, 1'b0, 1'b0, -1, 17);

        // Spurious rvalid in IDLE, then in REQ, with fill_req held high.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0_0000;
        step();
        check_eq("idle_rvalid_busy", LINE_W'(fill_busy), 0);
        mem_rvalid = 1'b0;
        fill_req   = 1'b1;
        fill_addr  = 32'h0000_0500;
        run_fill(32'h0000_0500, 32'h400, -1, 1'b1, 1'b1, -1, 17);
        // fill_req still high: accepted in the IDLE cycle, REQ the cycle after.
        step();
        check_eq("reaccept_busy", LINE_W'(fill_busy), 1);
        check_eq("reaccept_req", LINE_W'(mem_req), 1);
        check_eq("reaccept_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_0500));
        fill_req = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Reset during WAIT of beat 4, then a clean fill.
        run_fill(32'h0000_1234, 32'h500, -1, 1'b0, 1'b0, 4, 0);
        run_fill(32'h0000_0040, 32'h600, -1, 1'b0, 1'b0, -1, 17);

        // Top-of-memory line.
        run_fill(32'hFFFF_FFFC, 32'h700, -1, 1'b0, 1'b0, -1, 17);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
